// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, debounce, press/release pulses
// and hold-to-repeat per channel. All outputs are registered.
module button_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             inclk0,
  input  logic             i_Reset,
  input  logic [N_BTN-1:0] i_Btn,
  input  logic [N_BTN-1:0] i_RepeatEn,
  output logic [N_BTN-1:0] o_State,
  output logic [N_BTN-1:0] o_Down,
  output logic [N_BTN-1:0] o_Up,
  output logic [N_BTN-1:0] o_Repeat
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DBW-1:0]   DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0]   DB_ONE    = DBW'(1);
  localparam logic [RW-1:0]    DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]    RATE_LAST = RW'(REPEAT_RATE - 1);
  localparam logic [RW-1:0]    HOLD_ONE  = RW'(1);
  localparam logic [N_BTN-1:0] RELEASED  = ACTIVE_LOW ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [DBW-1:0]   r_db_cnt [N_BTN];
  logic [RW-1:0]    r_hold   [N_BTN];
  logic [N_BTN-1:0] r_first;
  logic [N_BTN-1:0] r_state;
  logic [N_BTN-1:0] r_down;
  logic [N_BTN-1:0] r_up;
  logic [N_BTN-1:0] r_rep;

  logic [N_BTN-1:0] w_lvl;
  logic [N_BTN-1:0] w_diff;
  logic [N_BTN-1:0] w_toggle;
  logic [N_BTN-1:0] w_fire;

  // The hold counter restarts from 0 after every pulse and is compared against the
  // delay before the first pulse and the rate afterwards, so it can never overflow.
  always_comb begin
    w_lvl    = ACTIVE_LOW ? ~r_sync2 : r_sync2;
    w_diff   = w_lvl ^ r_state;
    w_toggle = '0;
    w_fire   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_toggle[i] = w_diff[i] && (r_db_cnt[i] == DB_LAST);
      w_fire[i]   = r_state[i] && i_RepeatEn[i] && !w_toggle[i] &&
                    (r_hold[i] == (r_first[i] ? DLY_LAST : RATE_LAST));
    end
  end

  always_ff @(posedge inclk0 or negedge i_Reset) begin
    if (!i_Reset) begin
      r_sync1 <= RELEASED;
      r_sync2 <= RELEASED;
      r_first <= '1;
      r_state <= '0;
      r_down  <= '0;
      r_up    <= '0;
      r_rep   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_db_cnt[i] <= '0;
        r_hold[i]   <= '0;
      end
    end else begin
      r_sync1 <= i_Btn;
      r_sync2 <= r_sync1;
      r_state <= r_state ^ w_toggle;
      r_down  <= w_toggle & ~r_state;
      r_up    <= w_toggle & r_state;
      r_rep   <= w_fire;
      for (int i = 0; i < N_BTN; i++) begin
        if (!w_diff[i] || w_toggle[i]) r_db_cnt[i] <= '0;
        else                           r_db_cnt[i] <= r_db_cnt[i] + DB_ONE;

        if (!r_state[i] || !i_RepeatEn[i] || w_toggle[i]) begin
          r_hold[i]  <= '0;
          r_first[i] <= 1'b1;
        end else if (w_fire[i]) begin
          r_hold[i]  <= '0;
          r_first[i] <= 1'b0;
        end else begin
          r_hold[i]  <= r_hold[i] + HOLD_ONE;
        end
      end
    end
  end

  assign o_State  = r_state;
  assign o_Down   = r_down;
  assign o_Up     = r_up;
  assign o_Repeat = r_rep;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: cycle-level behavioural model compared every clock,
// plus directed scenarios with literal expected values.
module tb_button_conditioner;

  localparam int NB  = 3;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;

  logic          inclk0 = 1'b0;
  logic          i_Reset;
  logic [NB-1:0] i_Btn;
  logic [NB-1:0] i_RepeatEn;
  logic [NB-1:0] o_State, o_Down, o_Up, o_Repeat;

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .ACTIVE_LOW(1'b1)
  ) dut (
    .inclk0(inclk0), .i_Reset(i_Reset), .i_Btn(i_Btn), .i_RepeatEn(i_RepeatEn),
    .o_State(o_State), .o_Down(o_Down), .o_Up(o_Up), .o_Repeat(o_Repeat)
  );

  always #5 inclk0 = ~inclk0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_dn_seen = 0, n_up_seen = 0, n_rep_seen = 0;

  // model state: pressed-sense delay line, run lengths and hold time per channel
  logic [NB-1:0] p1, p2;
  logic [NB-1:0] m_st, m_down, m_up, m_rep;
  int m_run [NB];
  int m_k   [NB];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic tog;
    if (!i_Reset) begin
      p1 = '0; p2 = '0; m_st = '0; m_down = '0; m_up = '0; m_rep = '0;
      for (int c = 0; c < NB; c++) begin m_run[c] = 0; m_k[c] = 0; end
    end else begin
      for (int c = 0; c < NB; c++) begin
        tog = 1'b0;
        if (p2[c] != m_st[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin tog = 1'b1; m_run[c] = 0; end
        end else m_run[c] = 0;
        m_down[c] = tog & ~m_st[c];
        m_up[c]   = tog & m_st[c];
        m_rep[c]  = 1'b0;
        if (m_st[c] && i_RepeatEn[c] && !tog) begin
          m_k[c]++;
          if (m_k[c] >= RD && ((m_k[c] - RD) % RR) == 0) m_rep[c] = 1'b1;
        end else m_k[c] = 0;
        if (tog) m_st[c] = ~m_st[c];
      end
      p2 = p1;
      p1 = ~i_Btn;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge inclk0);
    #2;
  endtask

  int base_a, base_b;
  logic [NB-1:0] exp_v;

  initial begin
    i_Reset = 1'b0; i_Btn = 3'b111; i_RepeatEn = 3'b000;
    fork
      forever begin
        @(posedge inclk0);
        #1;
        model_step();
        chk("mon_state",  {29'd0, o_State},  {29'd0, m_st});
        chk("mon_down",   {29'd0, o_Down},   {29'd0, m_down});
        chk("mon_up",     {29'd0, o_Up},     {29'd0, m_up});
        chk("mon_repeat", {29'd0, o_Repeat}, {29'd0, m_rep});
        n_dn_seen  += $countones(o_Down);
        n_up_seen  += $countones(o_Up);
        n_rep_seen += $countones(o_Repeat);
      end
    join_none

    // 1: idle after reset
    step(2);
    chk("rst_outputs", {16'd0, o_State, o_Down, o_Up, o_Repeat}, 32'd0);
    i_Reset = 1'b1;
    step(100);
    chk("idle_state", {29'd0, o_State}, 32'd0);
    chk("idle_pulses", n_dn_seen + n_up_seen + n_rep_seen, 32'd0);

    // 2: single press and release on channel 1
    i_Btn = 3'b101;
    step(5);
    chk("s2_state_e5", {29'd0, o_State}, 32'd0);
    step(1);
    chk("s2_state_e6", {29'd0, o_State}, 32'd2);
    chk("s2_down_e6",  {29'd0, o_Down},  32'd2);
    chk("s2_model_down", {29'd0, m_down}, 32'd2);
    step(1);
    chk("s2_down_e7",  {29'd0, o_Down},  32'd0);
    i_Btn = 3'b111;
    step(5);
    chk("s2_up_e5",    {29'd0, o_Up},    32'd0);
    step(1);
    chk("s2_up_e6",    {29'd0, o_Up},    32'd2);
    chk("s2_state_rel", {29'd0, o_State}, 32'd0);
    chk("s2_model_up", {29'd0, m_up},    32'd2);
    step(4);

    // 3: glitch rejection on channel 0
    base_a = n_dn_seen + n_up_seen;
    for (int g = 0; g < 5; g++) begin
      i_Btn = 3'b110; step(3);
      i_Btn = 3'b111; step(3);
    end
    step(10);
    chk("s3_state", {29'd0, o_State}, 32'd0);
    chk("s3_pulses", n_dn_seen + n_up_seen - base_a, 32'd0);

    // 4: auto-repeat on channel 2
    i_RepeatEn = 3'b100;
    i_Btn = 3'b011;
    for (int e = 1; e <= 23; e++) begin
      step(1);
      exp_v = (e == 16 || e == 19 || e == 22) ? 3'b100 : 3'b000;
      chk($sformatf("s4_rep_e%0d", e), {29'd0, o_Repeat}, {29'd0, exp_v});
      chk($sformatf("s4_model_rep_e%0d", e), {29'd0, m_rep}, {29'd0, exp_v});
      exp_v = (e == 6) ? 3'b100 : 3'b000;
      chk($sformatf("s4_down_e%0d", e), {29'd0, o_Down}, {29'd0, exp_v});
    end
    i_Btn = 3'b111;
    step(6);
    chk("s4_up", {29'd0, o_Up}, 32'd4);
    base_b = n_rep_seen;
    step(20);
    chk("s4_no_rep_after_up", n_rep_seen - base_b, 32'd0);
    i_RepeatEn = 3'b000;
    i_Btn = 3'b011;
    step(30);
    chk("s4_held_state", {29'd0, o_State}, 32'd4);
    chk("s4_no_rep_disabled", n_rep_seen - base_b, 32'd0);
    i_Btn = 3'b111;
    step(10);
    // re-enable while held: model tracks the restart
    i_RepeatEn = 3'b100;
    i_Btn = 3'b011;
    step(12);
    i_RepeatEn = 3'b000;
    step(2);
    i_RepeatEn = 3'b100;
    step(30);
    i_Btn = 3'b111;
    i_RepeatEn = 3'b000;
    step(10);

    // 5: simultaneous press
    i_Btn = 3'b000;
    step(5);
    chk("s5_down_e5", {29'd0, o_Down}, 32'd0);
    step(1);
    chk("s5_down_e6", {29'd0, o_Down}, 32'd7);
    chk("s5_model_down", {29'd0, m_down}, 32'd7);
    i_Btn = 3'b111;
    step(6);
    chk("s5_up", {29'd0, o_Up}, 32'd7);
    step(4);

    // 6: reset mid-debounce, then reset while held
    i_Btn = 3'b110;
    step(3);
    i_Reset = 1'b0;
    #1;
    chk("s6_async_outputs", {16'd0, o_State, o_Down, o_Up, o_Repeat}, 32'd0);
    step(2);
    i_Reset = 1'b1;
    step(5);
    chk("s6_down_e5", {29'd0, o_Down}, 32'd0);
    step(1);
    chk("s6_down_e6", {29'd0, o_Down}, 32'd1);
    chk("s6_state_e6", {29'd0, o_State}, 32'd1);
    step(3);
    i_Reset = 1'b0;
    #1;
    chk("s6_async_state", {29'd0, o_State}, 32'd0);
    step(2);
    i_Reset = 1'b1;
    step(6);
    chk("s6_redown_e6", {29'd0, o_Down}, 32'd1);
    i_Btn = 3'b111;
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
